smem_sched: RTL
===============

Name: smem_sched

Overview:
- Sequencer and port arbiter for the shared 256x8 single-port s_memory.
- Runs the RC4 phases in fixed order: task1 (S[i]=i init), then KSA (task2a), then PRGA (task2b). Each phase is started with a one-cycle strobe and ended by that task's fin_strobe.
- Muxes the active task's address/data/wr_en onto the RAM. A host/debug read port owns the RAM only while the sequencer is idle or done.
- RAM q is wired directly to all clients outside this block. Latency is the RAM's own 1-cycle read.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- NUM_PHASES, 3, phases run per start: 1 = init only, 2 = init+KSA, 3 = all. Legal range 1..3.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run the phase sequence.
- busy  out  1  high from the accepted start until entry to DONE.
- done  out  1  high while in DONE; cleared by the next accepted start.
- err  out  1  phase timeout flag (Optional Feature only).
- phase  out  2  active phase: 0 none, 1 init, 2 KSA, 3 PRGA.
- t_start  out  3  one-cycle start strobes; bit0 task1, bit1 KSA, bit2 PRGA.
- t_fin  in  3  fin_strobe from each task, same bit order.
- t1_addr, t2a_addr, t2b_addr  in  ADDR_W  task addresses.
- t1_data, t2a_data, t2b_data  in  DATA_W  task write data.
- t1_wr_en, t2a_wr_en, t2b_wr_en  in  1  task write enables.
- host_req  in  1  host wants the RAM (read-only).
- host_addr  in  ADDR_W  host read address.
- host_gnt  out  1  host owns the RAM this cycle.
- mem_addr  out  ADDR_W  to s_memory address.
- mem_data  out  DATA_W  to s_memory data.
- mem_wren  out  1  to s_memory wren.

Behaviour:
- Reset (asynchronous, rst=0): state IDLE. busy=0, done=0, err=0, phase=0, t_start=0, host_gnt=0, mem_wren=0, mem_addr=0, mem_data=0. Reset mid-phase aborts immediately; the RAM keeps its partial contents.
- States: IDLE, P1_GO, P1_RUN, P2_GO, P2_RUN, P3_GO, P3_RUN, DONE.
- IDLE/DONE, start=1: go to P1_GO next cycle. done clears and busy sets on that edge. start in any other state is ignored.
- Pn_GO: lasts exactly one cycle. t_start[n-1]=1 for that cycle, then move to Pn_RUN.
- Pn_RUN: wait for t_fin[n-1]. On the fin cycle, go to P(n+1)_GO, or to DONE if n==NUM_PHASES. fin bits of non-active tasks are ignored.
- A fin arriving in the same cycle as t_start for that task counts as completion. This is a legal zero-length phase.
- phase=n throughout Pn_GO and Pn_RUN. Ownership passes on the edge after fin, with no dead cycle besides the GO cycle.
- RAM mux is combinational from state:
  - Pn_GO/Pn_RUN: mem_* = task n signals.
  - IDLE/DONE with host_gnt: mem_addr=host_addr, mem_data=0, mem_wren=0.
  - Otherwise: mem_addr=0, mem_data=0, mem_wren=0.
- Non-owner wr_en never reaches mem_wren.
- host_gnt = host_req & (IDLE|DONE) & ~start. A start in the same cycle beats the host. host_gnt drops combinationally as the sequence begins.
- Host read data appears on q one cycle after the address, per RAM latency. The host must hold host_req for the read-back cycle.
- busy=1 in all GO/RUN states.

Optional Feature:
- Macro SMEM_WATCHDOG_EN. Adds parameter TIMEOUT, default 4096.
- With the macro: a 16-bit cycle counter clears on every GO state and increments in RUN. If it reaches TIMEOUT before fin:
  - go to DONE with err=1;
  - no further t_start is issued;
  - err clears on the next accepted start or on reset.
- Without the macro: no counter; err is tied 0.

Test Plan:
- Reset, then start at cycle 5 with task models giving fin 300 cycles after each strobe -> t_start pulses 001, 010, 100 each exactly 1 cycle; phase steps 1,2,3; done=1 after the third fin; busy low the same cycle.
- Host read-out after done, host_addr stepping 0..255 -> host_gnt=1; q matches the RAM; mem_wren=0 throughout, even with t1_wr_en forced 1.
- t2a_wr_en=1 with t2a_addr=8'hAA during phase 1 -> mem_wren follows t1_wr_en only; RAM[AA] unchanged.
- Stray t_fin[2] during P1_RUN -> no state change; next start strobe is still 010 after t_fin[0].
- rst low during P2_RUN -> all outputs 0 within the same cycle; after release, start reruns from phase 1.
- NUM_PHASES=1 -> done after the task1 fin, with no t_start[1]. With SMEM_WATCHDOG_EN, TIMEOUT=16 and no fin -> err=1 and done=1 at RUN cycle 16.

Source files
------------

// File: rtl/smem_sched.sv
// rtl/smem_sched.sv - RC4 phase sequencer and s_memory port arbiter
// Optional phase watchdog enabled by defining SMEM_WATCHDOG_EN.
module smem_sched #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_PHASES = 3
`ifdef SMEM_WATCHDOG_EN
  ,
  parameter int TIMEOUT    = 4096
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        phase,
  output logic [2:0]        t_start,
  input  logic [2:0]        t_fin,
  input  logic [ADDR_W-1:0] t1_addr,
  input  logic [ADDR_W-1:0] t2a_addr,
  input  logic [ADDR_W-1:0] t2b_addr,
  input  logic [DATA_W-1:0] t1_data,
  input  logic [DATA_W-1:0] t2a_data,
  input  logic [DATA_W-1:0] t2b_data,
  input  logic              t1_wr_en,
  input  logic              t2a_wr_en,
  input  logic              t2b_wr_en,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P1_GO  = 3'd1,
    P1_RUN = 3'd2,
    P2_GO  = 3'd3,
    P2_RUN = 3'd4,
    P3_GO  = 3'd5,
    P3_RUN = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t state, state_n;
  logic   wd_trip;
  logic   idle_or_done;
  logic   accept_start;

  localparam state_t AFTER_P1 = (NUM_PHASES <= 1) ? DONE : P2_GO;
  localparam state_t AFTER_P2 = (NUM_PHASES <= 2) ? DONE : P3_GO;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign accept_start = idle_or_done && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

`ifdef SMEM_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        in_run;
  logic        in_go;

  assign in_go   = (state == P1_GO) || (state == P2_GO) || (state == P3_GO);
  assign in_run  = (state == P1_RUN) || (state == P2_RUN) || (state == P3_RUN);
  assign wd_trip = in_run && (wd_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (in_go)       wd_cnt <= '0;
      else if (in_run) wd_cnt <= wd_cnt + 16'd1;
      if (accept_start)                       err <= 1'b0;
      else if (wd_trip && state_n == DONE)    err <= 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign err     = 1'b0;
`endif

  // A fin seen in the GO cycle completes the phase immediately.
  always_comb begin
    state_n = state;
    t_start = 3'b000;
    phase   = 2'd0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = P1_GO;
      end
      P1_GO: begin
        t_start = 3'b001;
        phase   = 2'd1;
        busy    = 1'b1;
        state_n = t_fin[0] ? AFTER_P1 : P1_RUN;
      end
      P1_RUN: begin
        phase = 2'd1;
        busy  = 1'b1;
        if (t_fin[0])     state_n = AFTER_P1;
        else if (wd_trip) state_n = DONE;
      end
      P2_GO: begin
        t_start = 3'b010;
        phase   = 2'd2;
        busy    = 1'b1;
        state_n = t_fin[1] ? AFTER_P2 : P2_RUN;
      end
      P2_RUN: begin
        phase = 2'd2;
        busy  = 1'b1;
        if (t_fin[1])     state_n = AFTER_P2;
        else if (wd_trip) state_n = DONE;
      end
      P3_GO: begin
        t_start = 3'b100;
        phase   = 2'd3;
        busy    = 1'b1;
        state_n = t_fin[2] ? DONE : P3_RUN;
      end
      P3_RUN: begin
        phase = 2'd3;
        busy  = 1'b1;
        if (t_fin[2] || wd_trip) state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_n = P1_GO;
      end
      default: state_n = IDLE;
    endcase
  end

  // rst gates the grant so a held host_req cannot drive the RAM during reset.
  assign host_gnt = rst && host_req && idle_or_done && !start;

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    case (state)
      P1_GO, P1_RUN: begin
        mem_addr = t1_addr;
        mem_data = t1_data;
        mem_wren = t1_wr_en;
      end
      P2_GO, P2_RUN: begin
        mem_addr = t2a_addr;
        mem_data = t2a_data;
        mem_wren = t2a_wr_en;
      end
      P3_GO, P3_RUN: begin
        mem_addr = t2b_addr;
        mem_data = t2b_data;
        mem_wren = t2b_wr_en;
      end
      default: begin
        if (host_gnt) mem_addr = host_addr;
      end
    endcase
  end

endmodule
